// File: rtl/bp_me_pkg.sv
// Shared types for the wormhole memory responder: header layout, opcode and FSM state.
package bp_me_pkg;

    localparam int bp_flit_width_gp = 64;
    localparam int bp_cord_width_gp = 7;
    localparam int bp_len_width_gp  = 4;
    localparam int bp_cid_width_gp  = 2;
    localparam int bp_addr_width_gp = 8;
    localparam int bp_hdr_used_gp   = 2*bp_cord_width_gp + bp_len_width_gp
                                    + 2*bp_cid_width_gp + 1 + bp_addr_width_gp;

    typedef enum logic {
        e_mem_wh_rd = 1'b0,
        e_mem_wh_wr = 1'b1
    } bp_mem_wh_opcode_e;

    typedef enum logic [2:0] {
        e_ready,
        e_write_data,
        e_drain,
        e_send_hdr,
        e_send_data
    } bp_mem_wh_state_e;

    // Declared MSB first, so dst_cord lands in the LSBs of the flit.
    typedef struct packed {
        logic [bp_flit_width_gp-bp_hdr_used_gp-1:0] pad;
        logic [bp_addr_width_gp-1:0]                addr;
        bp_mem_wh_opcode_e                          opcode;
        logic [bp_cid_width_gp-1:0]                 src_cid;
        logic [bp_cord_width_gp-1:0]                src_cord;
        logic [bp_cid_width_gp-1:0]                 cid;
        logic [bp_len_width_gp-1:0]                 len;
        logic [bp_cord_width_gp-1:0]                dst_cord;
    } bp_mem_wh_hdr_s;

endpackage

// File: rtl/bp_mem_wormhole_responder_if.sv
// Ready-and link pair: each link is packed {v, data, ready_and_rev}, ready travelling upstream.
interface bp_mem_wormhole_responder_if #(
    parameter int flit_width_p = 64
);
    logic [flit_width_p+1:0] cmd_link;
    logic [flit_width_p+1:0] resp_link;

    modport master (output cmd_link, input resp_link);
    modport slave  (input cmd_link, output resp_link);
endinterface

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM; read data is registered and held until the next read.
module bsg_mem_1rw_sync #(
    parameter int width_p = 64,
    parameter int els_p   = 256,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic                     v_i,
    input  logic                     w_i,
    output logic [width_p-1:0]       data_o
);
    logic [width_p-1:0] r_mem [els_p];
    logic [width_p-1:0] r_data;

    always_ff @(posedge clk_i) begin
        if (v_i & w_i)
            r_mem[addr_i] <= data_i;
        else if (v_i)
            r_data <= r_mem[addr_i];
    end

    assign data_o = r_data;
endmodule

// File: rtl/bp_mem_wormhole_responder.sv
// Wormhole memory endpoint: one-flit reads, two-flit writes, malformed packets drained with a sticky error.
module bp_mem_wormhole_responder
    import bp_me_pkg::*;
#(
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4,
    parameter int cid_width_p  = 2,
    parameter int mem_els_p    = 256
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [cord_width_p-1:0] my_cord_i,
    input  logic [flit_width_p+1:0] cmd_link_i,
    output logic [flit_width_p+1:0] resp_link_o,
    output logic                    error_o
);
    localparam int addr_width_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int DST_LSB_LP    = 0;
    localparam int LEN_LSB_LP    = DST_LSB_LP + cord_width_p;
    localparam int CID_LSB_LP    = LEN_LSB_LP + len_width_p;
    localparam int SCORD_LSB_LP  = CID_LSB_LP + cid_width_p;
    localparam int SCID_LSB_LP   = SCORD_LSB_LP + cord_width_p;
    localparam int OP_LSB_LP     = SCID_LSB_LP + cid_width_p;
    localparam int ADDR_LSB_LP   = OP_LSB_LP + 1;
    localparam logic [addr_width_lp:0] mem_els_lp = (addr_width_lp+1)'(mem_els_p);

    logic                     w_cmd_v, w_resp_rdy, w_cmd_rdy, w_cmd_hs;
    logic [flit_width_p-1:0]  w_cmd_data;
    logic [len_width_p-1:0]   w_hdr_len;
    logic [cord_width_p-1:0]  w_hdr_scord;
    logic [cid_width_p-1:0]   w_hdr_scid;
    logic [addr_width_lp-1:0] w_hdr_addr;
    bp_mem_wh_opcode_e        w_hdr_op;
    logic                     w_addr_ok, w_hdr_bad;

    bp_mem_wh_state_e         r_state;
    logic                     r_live, r_error;
    logic [len_width_p-1:0]   r_drain_cnt;
    logic [cord_width_p-1:0]  r_src_cord;
    logic [cid_width_p-1:0]   r_src_cid;
    bp_mem_wh_opcode_e        r_op;
    logic [addr_width_lp-1:0] r_addr;

    logic                     w_ram_v, w_ram_w;
    logic [addr_width_lp-1:0] w_ram_addr;
    logic [flit_width_p-1:0]  w_ram_rdata;
    logic                     w_resp_v;
    logic [flit_width_p-1:0]  w_resp_hdr, w_resp_data;

    assign w_cmd_v    = cmd_link_i[flit_width_p+1];
    assign w_cmd_data = cmd_link_i[flit_width_p:1];
    assign w_resp_rdy = cmd_link_i[0];

    assign w_hdr_len   = w_cmd_data[LEN_LSB_LP +: len_width_p];
    assign w_hdr_scord = w_cmd_data[SCORD_LSB_LP +: cord_width_p];
    assign w_hdr_scid  = w_cmd_data[SCID_LSB_LP +: cid_width_p];
    assign w_hdr_op    = bp_mem_wh_opcode_e'(w_cmd_data[OP_LSB_LP]);
    assign w_hdr_addr  = w_cmd_data[ADDR_LSB_LP +: addr_width_lp];

    // Only reachable when mem_els_p is not a power of two.
    assign w_addr_ok = {1'b0, w_hdr_addr} < mem_els_lp;
    assign w_hdr_bad = ~w_addr_ok
                     | ((w_hdr_op == e_mem_wh_rd) ? (w_hdr_len != '0)
                                                  : (w_hdr_len != len_width_p'(1)));

    // r_live holds ready low until the first edge after reset releases.
    assign w_cmd_rdy = r_live & ((r_state == e_ready) | (r_state == e_write_data)
                                 | (r_state == e_drain));
    assign w_cmd_hs  = w_cmd_v & w_cmd_rdy;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= e_ready;
            r_live      <= 1'b0;
            r_error     <= 1'b0;
            r_drain_cnt <= '0;
            r_src_cord  <= '0;
            r_src_cid   <= '0;
            r_op        <= e_mem_wh_rd;
            r_addr      <= '0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                e_ready: if (w_cmd_hs) begin
                    r_src_cord  <= w_hdr_scord;
                    r_src_cid   <= w_hdr_scid;
                    r_op        <= w_hdr_op;
                    r_addr      <= w_hdr_addr;
                    r_drain_cnt <= w_hdr_len;
                    if (w_hdr_bad) begin
                        r_error <= 1'b1;
                        if (w_hdr_len != '0) r_state <= e_drain;
                    end else if (w_hdr_op == e_mem_wh_rd) begin
                        r_state <= e_send_hdr;
                    end else begin
                        r_state <= e_write_data;
                    end
                end
                e_write_data: if (w_cmd_hs) r_state <= e_send_hdr;
                e_drain: if (w_cmd_hs) begin
                    r_drain_cnt <= r_drain_cnt - len_width_p'(1);
                    if (r_drain_cnt == len_width_p'(1)) r_state <= e_ready;
                end
                e_send_hdr: if (w_resp_rdy)
                    r_state <= (r_op == e_mem_wh_rd) ? e_send_data : e_ready;
                e_send_data: if (w_resp_rdy) r_state <= e_ready;
                default: r_state <= e_ready;
            endcase
        end
    end

    assign w_ram_w    = (r_state == e_write_data);
    assign w_ram_v    = w_ram_w ? w_cmd_hs
                                : (w_cmd_hs & (r_state == e_ready) & ~w_hdr_bad
                                   & (w_hdr_op == e_mem_wh_rd));
    assign w_ram_addr = w_ram_w ? r_addr : w_hdr_addr;

    bsg_mem_1rw_sync #(
        .width_p (flit_width_p),
        .els_p   (mem_els_p)
    ) u_mem (
        .clk_i  (clk_i),
        .data_i (w_cmd_data),
        .addr_i (w_ram_addr),
        .v_i    (w_ram_v),
        .w_i    (w_ram_w),
        .data_o (w_ram_rdata)
    );

    always_comb begin
        w_resp_hdr = '0;
        w_resp_hdr[DST_LSB_LP +: cord_width_p]    = r_src_cord;
        w_resp_hdr[LEN_LSB_LP +: len_width_p]     = (r_op == e_mem_wh_rd) ? len_width_p'(1) : '0;
        w_resp_hdr[CID_LSB_LP +: cid_width_p]     = r_src_cid;
        w_resp_hdr[SCORD_LSB_LP +: cord_width_p]  = my_cord_i;
        w_resp_hdr[OP_LSB_LP]                     = r_op;
        w_resp_hdr[ADDR_LSB_LP +: addr_width_lp]  = r_addr;
    end

    assign w_resp_v = (r_state == e_send_hdr) | (r_state == e_send_data);

    always_comb begin
        w_resp_data = '0;
        if (r_state == e_send_hdr)       w_resp_data = w_resp_hdr;
        else if (r_state == e_send_data) w_resp_data = w_ram_rdata;
    end

    assign resp_link_o = {w_resp_v, w_resp_data, w_cmd_rdy};
    assign error_o     = r_error;
endmodule

// File: tb/tb_bp_mem_wormhole_responder.sv
// Bench for the wormhole memory responder: directed scenarios plus random traffic against a memory model.
module tb_bp_mem_wormhole_responder;
    import bp_me_pkg::*;

    localparam int FW = 64;
    localparam logic [6:0] MY_CORD = 7'h05;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_v = 1'b0;
    logic          resp_rdy = 1'b0;
    logic [FW-1:0] cmd_data = '0;
    logic          error;
    logic          resp_v, cmd_rdy;
    logic [FW-1:0] resp_data;
    int            total = 0;
    int            bad = 0;
    logic [FW-1:0] mem_m [int];
    int            keys [$];

    bp_mem_wormhole_responder_if #(.flit_width_p(FW)) u_if ();

    assign u_if.cmd_link = {cmd_v, cmd_data, resp_rdy};
    assign resp_v    = u_if.resp_link[FW+1];
    assign resp_data = u_if.resp_link[FW:1];
    assign cmd_rdy   = u_if.resp_link[0];

    bp_mem_wormhole_responder #(
        .flit_width_p (FW),
        .cord_width_p (7),
        .len_width_p  (4),
        .cid_width_p  (2),
        .mem_els_p    (256)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .my_cord_i   (MY_CORD),
        .cmd_link_i  (u_if.cmd_link),
        .resp_link_o (u_if.resp_link),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk_hdr(input logic [6:0] dst, input logic [3:0] len,
                                             input logic [1:0] cid, input logic [6:0] scord,
                                             input logic [1:0] scid, input logic op,
                                             input logic [7:0] addr);
        bp_mem_wh_hdr_s h;
        h          = '0;
        h.dst_cord = dst;
        h.len      = len;
        h.cid      = cid;
        h.src_cord = scord;
        h.src_cid  = scid;
        h.opcode   = bp_mem_wh_opcode_e'(op);
        h.addr     = addr;
        return h;
    endfunction

    function automatic logic [FW-1:0] cmd_hdr(input logic [6:0] scord, input logic [1:0] scid,
                                              input logic op, input logic [3:0] len,
                                              input logic [7:0] addr);
        return mk_hdr(MY_CORD, len, 2'd0, scord, scid, op, addr);
    endfunction

    function automatic logic [FW-1:0] resp_hdr(input logic [6:0] scord, input logic [1:0] scid,
                                               input logic op, input logic [7:0] addr);
        return mk_hdr(scord, op ? 4'd0 : 4'd1, scid, MY_CORD, 2'd0, op, addr);
    endfunction

    task automatic send_flit(input logic [FW-1:0] d, output bit ok);
        ok = 1'b0;
        cmd_v = 1'b1;
        cmd_data = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cmd_rdy === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_v = 1'b0;
    endtask

    task automatic recv_flit(input int stall, output logic [FW-1:0] got, output bit ok);
        ok = 1'b0;
        got = 'x;
        repeat (stall) begin @(posedge clk); #1; end
        resp_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (resp_v === 1'b1) begin got = resp_data; ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (u_if.resp_link !== '0 || error !== 1'b0) begin
            bad++; $display("FAIL reset_outputs resp_link=%h error=%b want 0/0", u_if.resp_link, error);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL rdy_before_edge got=%b want 0", cmd_rdy); end
        @(posedge clk); #1;
        total++;
        if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL rdy_after_edge got=%b want 1", cmd_rdy); end
    endtask

    task automatic test_write_ack();
        bit ok;
        logic [FW-1:0] got, exp;
        exp = resp_hdr(7'd3, 2'd1, 1'b1, 8'h10);
        send_flit(cmd_hdr(7'd3, 2'd1, 1'b1, 4'd1, 8'h10), ok);
        total++;
        if (!ok || resp_v !== 1'b0) begin bad++; $display("FAIL wr_hdr ok=%b resp_v=%b want 1/0", ok, resp_v); end
        send_flit(64'hDEAD_BEEF, ok);
        total++;
        if (!ok || resp_v !== 1'b1 || resp_data !== exp) begin
            bad++; $display("FAIL wr_ack_t1 ok=%b v=%b got=%h want %h", ok, resp_v, resp_data, exp);
        end
        recv_flit(0, got, ok);
        total++;
        if (!ok || got !== exp) begin bad++; $display("FAIL wr_ack got=%h want %h", got, exp); end
        total++;
        if (resp_v !== 1'b0 || cmd_rdy !== 1'b1) begin
            bad++; $display("FAIL wr_ack_only v=%b rdy=%b want 0/1", resp_v, cmd_rdy);
        end
        mem_m[16] = 64'hDEAD_BEEF;
        keys.push_back(16);
    endtask

    task automatic test_read();
        bit ok;
        logic [FW-1:0] got, exp;
        exp = resp_hdr(7'd9, 2'd2, 1'b0, 8'h10);
        send_flit(cmd_hdr(7'd9, 2'd2, 1'b0, 4'd0, 8'h10), ok);
        total++;
        if (!ok || resp_v !== 1'b1 || resp_data !== exp) begin
            bad++; $display("FAIL rd_hdr_t1 ok=%b v=%b got=%h want %h", ok, resp_v, resp_data, exp);
        end
        recv_flit(0, got, ok);
        total++;
        if (!ok || got !== exp) begin bad++; $display("FAIL rd_hdr got=%h want %h", got, exp); end
        recv_flit(0, got, ok);
        total++;
        if (!ok || got !== mem_m[16]) begin bad++; $display("FAIL rd_data got=%h want %h", got, mem_m[16]); end
        total++;
        if (resp_v !== 1'b0) begin bad++; $display("FAIL rd_end resp_v=%b want 0", resp_v); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [FW-1:0] got, exp;
        exp = resp_hdr(7'd11, 2'd3, 1'b0, 8'h10);
        resp_rdy = 1'b0;
        send_flit(cmd_hdr(7'd11, 2'd3, 1'b0, 4'd0, 8'h10), ok);
        for (int c = 0; c < 5; c++) begin
            total++;
            if (!ok || resp_v !== 1'b1 || resp_data !== exp || cmd_rdy !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold c=%0d v=%b rdy=%b got=%h want %h", c, resp_v, cmd_rdy, resp_data, exp);
            end
            @(posedge clk); #1;
        end
        recv_flit(0, got, ok);
        total++;
        if (!ok || got !== exp) begin bad++; $display("FAIL stall_hdr got=%h want %h", got, exp); end
        recv_flit(0, got, ok);
        total++;
        if (!ok || got !== mem_m[16]) begin bad++; $display("FAIL stall_data got=%h want %h", got, mem_m[16]); end
    endtask

    task automatic test_malformed();
        bit ok, all_ok;
        logic [FW-1:0] got, junk;
        junk = mk_hdr(7'd0, 4'd2, 2'd0, 7'd0, 2'd0, 1'b1, 8'h10);
        send_flit(cmd_hdr(7'd4, 2'd0, 1'b1, 4'd3, 8'h10), ok);
        all_ok = ok;
        for (int i = 0; i < 3; i++) begin
            send_flit(junk | {$urandom, 32'h0}, ok);
            all_ok &= ok;
        end
        total++;
        if (!all_ok || error !== 1'b1) begin bad++; $display("FAIL drain_wr ok=%b error=%b want 1/1", all_ok, error); end
        all_ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (resp_v !== 1'b0 || cmd_rdy !== 1'b1) all_ok = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (!all_ok) begin bad++; $display("FAIL drain_no_resp got=0 want 1"); end
        send_flit(cmd_hdr(7'd4, 2'd0, 1'b0, 4'd0, 8'h10), ok);
        recv_flit(0, got, ok);
        recv_flit(0, got, ok);
        total++;
        if (!ok || got !== mem_m[16]) begin bad++; $display("FAIL drain_old_val got=%h want %h", got, mem_m[16]); end
        // Maximum length: exactly 15 flits must be swallowed before the next header.
        send_flit(cmd_hdr(7'd4, 2'd0, 1'b0, 4'd15, 8'h10), ok);
        all_ok = ok;
        for (int i = 0; i < 15; i++) begin
            send_flit(junk, ok);
            all_ok &= ok;
        end
        total++;
        if (!all_ok || resp_v !== 1'b0) begin bad++; $display("FAIL drain_max ok=%b v=%b want 1/0", all_ok, resp_v); end
        send_flit(cmd_hdr(7'd6, 2'd1, 1'b0, 4'd0, 8'h10), ok);
        recv_flit(0, got, ok);
        total++;
        if (!ok || got !== resp_hdr(7'd6, 2'd1, 1'b0, 8'h10)) begin
            bad++; $display("FAIL drain_max_next got=%h want %h", got, resp_hdr(7'd6, 2'd1, 1'b0, 8'h10));
        end
        recv_flit(0, got, ok);
        total++;
        if (!ok || got !== mem_m[16]) begin bad++; $display("FAIL drain_max_data got=%h want %h", got, mem_m[16]); end
    endtask

    task automatic test_random();
        bit ok;
        logic          op;
        logic [7:0]    addr;
        logic [6:0]    scord;
        logic [1:0]    scid;
        logic [FW-1:0] d, got, exp;
        for (int n = 0; n < 24; n++) begin
            op    = (keys.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            addr  = op ? 8'($urandom_range(0, 255)) : 8'(keys[$urandom_range(0, keys.size()-1)]);
            scord = 7'($urandom);
            scid  = 2'($urandom);
            d     = {$urandom, $urandom};
            send_flit(cmd_hdr(scord, scid, op, op ? 4'd1 : 4'd0, addr), ok);
            if (op) send_flit(d, ok);
            exp = resp_hdr(scord, scid, op, addr);
            recv_flit(int'($urandom_range(0, 3)), got, ok);
            total++;
            if (!ok || got !== exp) begin bad++; $display("FAIL rand_hdr n=%0d got=%h want %h", n, got, exp); end
            if (op) begin
                if (!mem_m.exists(int'(addr))) keys.push_back(int'(addr));
                mem_m[int'(addr)] = d;
            end else begin
                recv_flit(int'($urandom_range(0, 3)), got, ok);
                total++;
                if (!ok || got !== mem_m[int'(addr)]) begin
                    bad++; $display("FAIL rand_data n=%0d got=%h want %h", n, got, mem_m[int'(addr)]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int dhs, acc;
        logic [FW-1:0] got, exp [4];
        logic [FW-1:0] q [$];
        for (int k = 0; k < 2; k++) begin
            got = {$urandom, $urandom};
            send_flit(cmd_hdr(7'd2, 2'd0, 1'b1, 4'd1, k ? 8'd255 : 8'd0), ok);
            send_flit(got, ok);
            mem_m[k ? 255 : 0] = got;
            recv_flit(0, got, ok);
            total++;
            if (!ok || got !== resp_hdr(7'd2, 2'd0, 1'b1, k ? 8'd255 : 8'd0)) begin
                bad++; $display("FAIL b2b_wr k=%0d got=%h", k, got);
            end
        end
        exp[0] = resp_hdr(7'd8, 2'd1, 1'b0, 8'd0);
        exp[1] = mem_m[0];
        exp[2] = resp_hdr(7'd8, 2'd2, 1'b0, 8'd255);
        exp[3] = mem_m[255];
        dhs = -1;
        acc = -1;
        send_flit(cmd_hdr(7'd8, 2'd1, 1'b0, 4'd0, 8'd0), ok);
        resp_rdy = 1'b1;
        cmd_v    = 1'b1;
        cmd_data = cmd_hdr(7'd8, 2'd2, 1'b0, 4'd0, 8'd255);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_v === 1'b1) begin
                q.push_back(resp_data);
                if (q.size() == 2) dhs = c;
            end
            if (cmd_v && cmd_rdy === 1'b1 && acc < 0) acc = c;
            @(posedge clk); #1;
            if (acc == c) cmd_v = 1'b0;
        end
        resp_rdy = 1'b0;
        cmd_v    = 1'b0;
        total++;
        if (dhs < 0 || acc != dhs + 1) begin bad++; $display("FAIL b2b_accept got=%0d want %0d", acc, dhs + 1); end
        total++;
        if (q.size() != 4) begin
            bad++; $display("FAIL b2b_count got=%0d want 4", q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (q[i] !== exp[i]) begin bad++; $display("FAIL b2b_flit%0d got=%h want %h", i, q[i], exp[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, quiet;
        logic [FW-1:0] got, d;
        d = {$urandom, $urandom};
        send_flit(cmd_hdr(7'd1, 2'd1, 1'b1, 4'd1, 8'h22), ok);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (u_if.resp_link !== '0 || error !== 1'b0) begin
            bad++; $display("FAIL mid_reset_out resp_link=%h error=%b want 0/0", u_if.resp_link, error);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_m.delete();
        keys.delete();
        quiet = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (resp_v !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet || cmd_rdy !== 1'b1) begin bad++; $display("FAIL mid_reset_quiet quiet=%b rdy=%b want 1/1", quiet, cmd_rdy); end
        send_flit(cmd_hdr(7'd1, 2'd1, 1'b1, 4'd1, 8'h22), ok);
        send_flit(d, ok);
        recv_flit(0, got, ok);
        total++;
        if (!ok || got !== resp_hdr(7'd1, 2'd1, 1'b1, 8'h22)) begin
            bad++; $display("FAIL mid_reset_wr got=%h want %h", got, resp_hdr(7'd1, 2'd1, 1'b1, 8'h22));
        end
        send_flit(cmd_hdr(7'd1, 2'd1, 1'b0, 4'd0, 8'h22), ok);
        recv_flit(0, got, ok);
        recv_flit(1, got, ok);
        total++;
        if (!ok || got !== d) begin bad++; $display("FAIL mid_reset_rd got=%h want %h", got, d); end
    endtask

    initial begin
        test_reset();
        test_write_ack();
        test_read();
        test_stall();
        test_malformed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
